serial_parity_rx: RTL and testbench

Serial frame receiver with parity checking, the consumer-side stage for the parity generator. It samples a single-wire serial stream (start bit, DATA_W data bits LSB first, parity bit, stop bit) on qualifying bit-enable strobes. It deserialises the data word, recomputes odd or even parity over data plus received parity bit, and presents the word with one-cycle valid and error flags to downstream logic.

---
 rtl/parity_pkg.sv | 14 +
 rtl/serial_parity_rx_if.sv | 24 ++
 rtl/parity_acc.sv | 22 ++
 rtl/serial_parity_rx.sv | 100 ++++++++++
 tb/tb_serial_parity_rx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Types and constants shared by the parity frame transmitter and receiver.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial line in, deserialised word and status out; master drives the line.
interface serial_parity_rx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              par_err;
  logic              frm_err;
  logic              busy;

  modport master (
    output bit_en, sin,
    input  dout, dout_valid, par_err, frm_err, busy
  );

  modport slave (
    input  bit_en, sin,
    output dout, dout_valid, par_err, frm_err, busy
  );

endinterface

// File: rtl/parity_acc.sv
// One-bit running XOR with synchronous load of an initial value.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic init,
  input  logic en,
  input  logic din,
  output logic acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= init;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, parity, stop; flags
// parity and framing errors alongside a one-cycle valid pulse.
module serial_parity_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = PAR_ODD
) (
  input logic              clk,
  input logic              rst_n,
  serial_parity_rx_if.slave bus
);

  localparam int unsigned    CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_next;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              par_err;
  logic              frm_err;
  logic              start;
  logic              acc_en;
  logic              acc;

  assign start  = bus.bit_en & ~bus.sin & (state == IDLE);
  assign acc_en = bus.bit_en & ((state == DATA) || (state == PARITY));

  // Right shift so the first data bit received lands in bit 0.
  always_comb begin
    shift_next = shreg;
    shift_next[DATA_W-1] = bus.sin;
    for (int i = 0; i < DATA_W - 1; i++) begin
      shift_next[i] = shreg[i+1];
    end
  end

  parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start),
    .init  (ODD),
    .en    (acc_en),
    .din   (bus.sin),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (bus.bit_en) begin
        unique case (state)
          IDLE: begin
            if (!bus.sin) begin
              state <= DATA;
              cnt   <= '0;
              shreg <= '0;
            end
          end
          DATA: begin
            shreg <= shift_next;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= PARITY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PARITY: state <= STOP;
          STOP: begin
            state      <= IDLE;
            dout       <= shreg;
            par_err    <= acc;
            frm_err    <= ~bus.sin;
            dout_valid <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.par_err    = par_err;
  assign bus.frm_err    = frm_err;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Drives odd- and even-parity receivers with one shared line and checks both
// against a frame-level model built from the received sample stream.
module tb_serial_parity_rx;
  import parity_pkg::*;

  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_en = 1'b0;
  logic sin = 1'b1;

  always #5 clk = ~clk;

  serial_parity_rx_if #(.DATA_W(DATA_W)) rx_odd ();
  serial_parity_rx_if #(.DATA_W(DATA_W)) rx_even ();

  assign rx_odd.bit_en  = bit_en;
  assign rx_odd.sin     = sin;
  assign rx_even.bit_en = bit_en;
  assign rx_even.sin    = sin;

  serial_parity_rx #(.DATA_W(DATA_W), .ODD(PAR_ODD)) u_dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rx_odd)
  );

  serial_parity_rx #(.DATA_W(DATA_W), .ODD(PAR_EVEN)) u_dut_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rx_even)
  );

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Frame-level model: samples after a start bit are collected until a whole frame.
  bit                in_frame = 1'b0;
  logic              samples[$];
  logic              exp_valid = 1'b0;
  logic [DATA_W-1:0] exp_dout = '0;
  logic              exp_perr_odd = 1'b0;
  logic              exp_perr_even = 1'b0;
  logic              exp_frm = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    in_frame      = 1'b0;
    samples.delete();
    exp_valid     = 1'b0;
    exp_dout      = '0;
    exp_perr_odd  = 1'b0;
    exp_perr_even = 1'b0;
    exp_frm       = 1'b0;
  endfunction

  function automatic void model_step(input logic be, input logic s);
    int ones;
    exp_valid = 1'b0;
    if (be) begin
      if (!in_frame) begin
        if (!s) begin
          in_frame = 1'b1;
          samples.delete();
        end
      end else begin
        samples.push_back(s);
        if (samples.size() == DATA_W + 2) begin
          for (int i = 0; i < DATA_W; i++) exp_dout[i] = samples[i];
          ones          = $countones(exp_dout) + (samples[DATA_W] ? 1 : 0);
          exp_perr_odd  = (ones % 2) == 0;
          exp_perr_even = (ones % 2) == 1;
          exp_frm       = !samples[DATA_W+1];
          exp_valid     = 1'b1;
          in_frame      = 1'b0;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    if (rx_odd.dout_valid === 1'b1) pulses++;
    check_eq("odd.valid", rx_odd.dout_valid, exp_valid);
    check_eq("even.valid", rx_even.dout_valid, exp_valid);
    check_eq("odd.busy", rx_odd.busy, in_frame);
    check_eq("even.busy", rx_even.busy, in_frame);
    check_eq("odd.dout", rx_odd.dout, exp_dout);
    check_eq("even.dout", rx_even.dout, exp_dout);
    check_eq("odd.par_err", rx_odd.par_err, exp_perr_odd);
    check_eq("even.par_err", rx_even.par_err, exp_perr_even);
    check_eq("odd.frm_err", rx_odd.frm_err, exp_frm);
    check_eq("even.frm_err", rx_even.frm_err, exp_frm);
  endtask

  // Called at a falling edge; drives one cycle and checks after the next one.
  task automatic cycle(input logic be, input logic s);
    bit_en = be;
    sin    = s;
    @(posedge clk);
    model_step(be, s);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_bit(input logic b, input int period, input bit noise);
    for (int k = 1; k < period; k++) cycle(1'b0, noise ? (($urandom % 2) != 0) : 1'b1);
    cycle(1'b1, b);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic stop,
                            input int period, input bit noise);
    send_bit(1'b0, period, noise);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], period, noise);
    send_bit(par, period, noise);
    send_bit(stop, period, noise);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst.dout", {rx_odd.dout, rx_even.dout}, '0);
    check_eq("rst.valid", {rx_odd.dout_valid, rx_even.dout_valid}, '0);
    check_eq("rst.busy", {rx_odd.busy, rx_even.busy}, '0);
    check_eq("rst.err", {rx_odd.par_err, rx_even.par_err, rx_odd.frm_err, rx_even.frm_err}, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic odd_par(input logic [DATA_W-1:0] d);
    return ~(^d);
  endfunction

  initial begin
    int p0;
    @(negedge clk);
    apply_reset();
    idle(2);

    p0 = pulses;
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0);
    idle(3);
    check_eq("a5.pulses", pulses - p0, 1);

    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0);
    idle(2);

    p0 = pulses;
    send_frame(8'h00, 1'b1, 1'b0, 1, 1'b0);
    idle(2);
    check_eq("frm.pulses", pulses - p0, 1);

    p0 = pulses;
    send_frame(8'h3C, 1'b1, 1'b1, 3, 1'b1);
    idle(2);
    check_eq("slow.pulses", pulses - p0, 1);

    // Abandon a frame part-way through its data bits.
    p0 = pulses;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
    apply_reset();
    idle(3);
    check_eq("rst.pulses", pulses - p0, 0);
    send_frame(8'h81, 1'b1, 1'b1, 1, 1'b0);
    idle(2);

    p0 = pulses;
    send_frame(8'h01, odd_par(8'h01), 1'b1, 1, 1'b0);
    send_frame(8'h80, odd_par(8'h80), 1'b1, 1, 1'b0);
    send_frame(8'hFF, odd_par(8'hFF), 1'b1, 1, 1'b0);
    idle(3);
    check_eq("b2b.pulses", pulses - p0, 3);

    for (int f = 0; f < 150; f++) begin
      logic [DATA_W-1:0] d;
      logic par;
      logic stop;
      int gap;
      d    = DATA_W'($urandom);
      par  = (($urandom % 4) == 0) ? ~odd_par(d) : odd_par(d);
      stop = ($urandom % 8) != 0;
      send_frame(d, par, stop, 1 + int'($urandom % 3), 1'b1);
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) begin
        if (($urandom % 2) != 0) cycle(1'b0, ($urandom % 2) != 0);
        else cycle(1'b1, 1'b1);
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
